multicycle_controller: RTL and testbench

Multi-cycle main control FSM for the LEGv8 datapath. It sequences FETCH, DECODE, EXEC, MEM and WB per instruction, and drives datapath strobes from the current state and the latched instruction class. It adds a memory ready/wait handshake with a timeout, plus CBNZ and unconditional B support. It sits between the instruction register, the memory interface and the datapath mux/ALU controls.

---
 rtl/ctrl_pkg.sv | 51 +++++
 rtl/multicycle_controller_op_decoder.sv | 33 +++
 rtl/multicycle_controller.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle control FSM:
// state/op-class encodings, opcode match patterns and ALUOp codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_RTYPE = 3'd1,
        OP_LDUR  = 3'd2,
        OP_STUR  = 3'd3,
        OP_CBZ   = 3'd4,
        OP_CBNZ  = 3'd5,
        OP_B     = 3'd6
    } op_class_t;

    // Opcode patterns over IR[31:21]; a cleared mask bit is a don't-care.
    localparam logic [10:0] RTYPE_MASK  = 11'b10011110111;
    localparam logic [10:0] RTYPE_MATCH = 11'b10001010000;
    localparam logic [10:0] LDUR_MASK   = 11'b11111111111;
    localparam logic [10:0] LDUR_MATCH  = 11'b11111000010;
    localparam logic [10:0] STUR_MASK   = 11'b11111111111;
    localparam logic [10:0] STUR_MATCH  = 11'b11111000000;
    localparam logic [10:0] CBZ_MASK    = 11'b11111111000;
    localparam logic [10:0] CBZ_MATCH   = 11'b10110100000;
    localparam logic [10:0] CBNZ_MASK   = 11'b11111111000;
    localparam logic [10:0] CBNZ_MATCH  = 11'b10110101000;
    localparam logic [10:0] B_MASK      = 11'b11111100000;
    localparam logic [10:0] B_MATCH     = 11'b00010100000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_CB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic TRAP_ILLEGAL = 1'b0;
    localparam logic TRAP_TIMEOUT = 1'b1;

    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] mask,
                                      input logic [10:0] match);
        return (op & mask) == match;
    endfunction

endpackage

// File: rtl/multicycle_controller_op_decoder.sv
// Combinational opcode classifier; disabled optional ops decode as NONE
// so the controller treats them exactly like any other illegal opcode.
module op_decoder
    import ctrl_pkg::*;
#(
    parameter int unsigned EN_CBNZ = 1,
    parameter int unsigned EN_B    = 1
) (
    input  logic [10:0] ins_op,
    output op_class_t   op_class,
    output logic        legal
);

    always_comb begin
        op_class = OP_NONE;
        if (op_match(ins_op, RTYPE_MASK, RTYPE_MATCH)) begin
            op_class = OP_RTYPE;
        end else if (op_match(ins_op, LDUR_MASK, LDUR_MATCH)) begin
            op_class = OP_LDUR;
        end else if (op_match(ins_op, STUR_MASK, STUR_MATCH)) begin
            op_class = OP_STUR;
        end else if (op_match(ins_op, CBZ_MASK, CBZ_MATCH)) begin
            op_class = OP_CBZ;
        end else if ((EN_CBNZ != 0) && op_match(ins_op, CBNZ_MASK, CBNZ_MATCH)) begin
            op_class = OP_CBNZ;
        end else if ((EN_B != 0) && op_match(ins_op, B_MASK, B_MATCH)) begin
            op_class = OP_B;
        end
    end

    assign legal = (op_class != OP_NONE);

endmodule

// File: rtl/multicycle_controller.sv
// LEGv8 multi-cycle main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory ready/wait handshake with timeout trap, CBZ/CBNZ/B support.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned EN_CBNZ     = 1,
    parameter int unsigned EN_B        = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] ins_op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        mem_to_reg,
    output logic        reg2loc,
    output logic [2:0]  state,
    output logic        trap,
    output logic        trap_cause
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t          state_q, state_d;
    op_class_t       class_q, class_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic            trap_q, trap_d;
    logic            cause_q, cause_d;

    op_class_t       dec_class;
    logic            dec_legal;
    logic            in_wait_state;
    logic            expire;

    op_decoder #(
        .EN_CBNZ (EN_CBNZ),
        .EN_B    (EN_B)
    ) u_op_decoder (
        .ins_op   (ins_op),
        .op_class (dec_class),
        .legal    (dec_legal)
    );

    assign in_wait_state = (state_q == ST_FETCH) || (state_q == ST_MEM);
    // Ready on the expiry cycle wins, so expiry is only taken with ready low.
    assign expire = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST) && !mem_ready;

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        trap_d  = trap_q;
        cause_d = cause_q;
        wait_d  = wait_q;

        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (expire) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = TRAP_TIMEOUT;
                end
            end
            ST_DECODE: begin
                class_d = dec_class;
                if (dec_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = TRAP_ILLEGAL;
                end
            end
            ST_EXEC: begin
                case (class_q)
                    OP_RTYPE:              state_d = ST_WB;
                    OP_LDUR, OP_STUR:      state_d = ST_MEM;
                    OP_CBZ, OP_CBNZ, OP_B: state_d = ST_FETCH;
                    default: begin
                        state_d = ST_TRAP;
                        trap_d  = 1'b1;
                        cause_d = TRAP_ILLEGAL;
                    end
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = (class_q == OP_LDUR) ? ST_WB : ST_FETCH;
                end else if (expire) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = TRAP_TIMEOUT;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: begin
                state_d = ST_TRAP;
                trap_d  = 1'b1;
                cause_d = TRAP_ILLEGAL;
            end
        endcase

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (in_wait_state && !mem_ready) begin
            wait_d = wait_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            class_q <= OP_NONE;
            wait_q  <= '0;
            trap_q  <= 1'b0;
            cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            wait_q  <= wait_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    // Strobes decode from state and latched class only; gating with rst_n
    // makes them drop the instant reset is asserted.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALUOP_ADD;
        mem_to_reg = 1'b0;
        reg2loc    = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                ST_EXEC: begin
                    case (class_q)
                        OP_RTYPE: alu_op = ALUOP_FUNCT;
                        OP_LDUR:  alu_src = 1'b1;
                        OP_STUR: begin
                            alu_src = 1'b1;
                            reg2loc = 1'b1;
                        end
                        OP_CBZ: begin
                            alu_op   = ALUOP_CB;
                            reg2loc  = 1'b1;
                            pc_write = zero;
                            pc_src   = 1'b1;
                        end
                        OP_CBNZ: begin
                            alu_op   = ALUOP_CB;
                            reg2loc  = 1'b1;
                            pc_write = ~zero;
                            pc_src   = 1'b1;
                        end
                        OP_B: begin
                            pc_write = 1'b1;
                            pc_src   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    mem_read  = (class_q == OP_LDUR);
                    mem_write = (class_q == OP_STUR);
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (class_q == OP_LDUR);
                end
                default: ;
            endcase
        end
    end

    assign state      = state_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: each instruction is expanded into its expected per-cycle
// output timeline, queued, and compared by an independent monitor.
module tb_multicycle_controller;

    localparam int MT = 16;

    localparam int K_R    = 0;
    localparam int K_LDUR = 1;
    localparam int K_STUR = 2;
    localparam int K_CBZ  = 3;
    localparam int K_CBNZ = 4;
    localparam int K_B    = 5;
    localparam int K_ILL  = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] ins_op = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, pc_src, ir_write, mem_read, mem_write, reg_write;
    logic        alu_src, mem_to_reg, reg2loc, trap, trap_cause;
    logic [1:0]  alu_op;
    logic [2:0]  state;

    logic [10:0] cur_op = '0;
    logic        cur_z = 1'b0;

    logic [15:0] exp_q[$];
    logic [15:0] async_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    multicycle_controller #(
        .MEM_TIMEOUT (MT),
        .EN_CBNZ     (1),
        .EN_B        (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ins_op     (ins_op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .mem_to_reg (mem_to_reg),
        .reg2loc    (reg2loc),
        .state      (state),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    function automatic logic [15:0] vec(input logic [2:0] st, input logic pcw, input logic pcs,
                                        input logic irw, input logic mrd, input logic mwr,
                                        input logic rgw, input logic asrc, input logic [1:0] aop,
                                        input logic m2r, input logic r2l, input logic tr,
                                        input logic tc);
        return {st, pcw, pcs, irw, mrd, mwr, rgw, asrc, aop, m2r, r2l, tr, tc};
    endfunction

    task automatic check(input string name, input logic [15:0] e);
        logic [15:0] a;
        a = {state, pc_write, pc_src, ir_write, mem_read, mem_write, reg_write,
             alu_src, alu_op, mem_to_reg, reg2loc, trap, trap_cause};
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s t=%0t: got state=%0d outs=%b, expected state=%0d outs=%b",
                     name, $time, a[15:13], a[12:0], e[15:13], e[12:0]);
        end
    endtask

    // Monitor: one expected entry per cycle at the falling edge, plus
    // mid-cycle checks for the asynchronous reset response.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", e);
            end
            if (async_q.size() > 0) begin
                #3;
                e = async_q.pop_front();
                check("async_reset", e);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input logic rdy, input logic [15:0] e);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        ins_op    = cur_op;
        zero      = cur_z;
        mem_ready = rdy;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst_n     = 1'b0;
            mem_ready = 1'($urandom_range(0, 1));
            exp_q.push_back(16'h0000);
        end
    endtask

    task automatic trap_cycles(input logic cause, input int n);
        for (int i = 0; i < n; i++) begin
            cur_z = 1'($urandom_range(0, 1));
            cyc(1'($urandom_range(0, 1)), vec(3'd5, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, cause));
        end
    endtask

    // A wait of MT or more cycles never sees ready: MT busy cycles, then TRAP.
    task automatic wait_phase(input int waits, input logic [15:0] busy_v,
                              input logic [15:0] done_v, output bit timed_out);
        if (waits >= MT) begin
            for (int i = 0; i < MT; i++) cyc(1'b0, busy_v);
            timed_out = 1'b1;
        end else begin
            for (int i = 0; i < waits; i++) cyc(1'b0, busy_v);
            cyc(1'b1, done_v);
            timed_out = 1'b0;
        end
    endtask

    function automatic logic [10:0] gen_op(input int kind);
        logic [10:0] op;
        logic [10:0] r;
        r = 11'($urandom);
        case (kind)
            K_R: begin
                op    = 11'b10001010000;
                op[9] = r[9];
                op[8] = r[8];
                op[3] = r[3];
            end
            K_LDUR: op = 11'b11111000010;
            K_STUR: op = 11'b11111000000;
            K_CBZ:  op = {8'b10110100, r[2:0]};
            K_CBNZ: op = {8'b10110101, r[2:0]};
            K_B:    op = {6'b000101, r[4:0]};
            default: begin
                case (r[1:0])
                    2'd0:    op = 11'b11111111111;
                    2'd1:    op = 11'b00000000000;
                    2'd2:    op = 11'b11111000001;
                    default: op = 11'b10110110000;
                endcase
            end
        endcase
        return op;
    endfunction

    task automatic run_instr(input logic [10:0] op, input int kind, input int fw,
                             input int mw, input logic z);
        bit to;
        logic [15:0] ev;
        cur_op = op;
        cur_z  = z;
        wait_phase(fw, vec(3'd0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0),
                       vec(3'd0, 1, 0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0), to);
        if (to) begin
            trap_cycles(1'b1, 4);
            do_reset(2);
            return;
        end
        cyc(1'($urandom_range(0, 1)), vec(3'd1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        if (kind == K_ILL) begin
            trap_cycles(1'b0, 10);
            do_reset(2);
            return;
        end
        case (kind)
            K_R:     ev = vec(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0);
            K_LDUR:  ev = vec(3'd2, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0);
            K_STUR:  ev = vec(3'd2, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 1, 0, 0);
            K_CBZ:   ev = vec(3'd2, z, 1, 0, 0, 0, 0, 0, 2'b01, 0, 1, 0, 0);
            K_CBNZ:  ev = vec(3'd2, ~z, 1, 0, 0, 0, 0, 0, 2'b01, 0, 1, 0, 0);
            default: ev = vec(3'd2, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        endcase
        cyc(1'($urandom_range(0, 1)), ev);
        if (kind == K_LDUR || kind == K_STUR) begin
            ev = (kind == K_LDUR) ? vec(3'd3, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0)
                                  : vec(3'd3, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0);
            wait_phase(mw, ev, ev, to);
            if (to) begin
                trap_cycles(1'b1, 4);
                do_reset(2);
                return;
            end
        end
        if (kind == K_R || kind == K_LDUR) begin
            cyc(1'($urandom_range(0, 1)),
                vec(3'd4, 0, 0, 0, 0, 0, 1, 0, 2'b00, (kind == K_LDUR), 0, 0, 0));
        end
    endtask

    // STUR interrupted by reset in the middle of its first MEM wait cycle.
    task automatic stur_reset();
        cur_op = 11'b11111000000;
        cur_z  = 1'b0;
        cyc(1'b1, vec(3'd0, 1, 0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        cyc(1'b0, vec(3'd1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        cyc(1'b0, vec(3'd2, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 1, 0, 0));
        cyc(1'b0, vec(3'd3, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0));
        async_q.push_back(16'h0000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        do_reset(2);
    endtask

    initial begin
        int kind;
        int fw;
        int mw;
        do_reset(3);
        run_instr(11'b10001011000, K_R, 0, 0, 1'b0);
        run_instr(11'b11111000010, K_LDUR, 0, 3, 1'b0);
        run_instr(gen_op(K_CBZ), K_CBZ, 0, 0, 1'b1);
        run_instr(gen_op(K_CBNZ), K_CBNZ, 0, 0, 1'b1);
        run_instr(gen_op(K_CBNZ), K_CBNZ, 1, 0, 1'b0);
        run_instr(gen_op(K_B), K_B, 2, 0, 1'b0);
        run_instr(11'b11111111111, K_ILL, 0, 0, 1'b0);
        run_instr(gen_op(K_R), K_R, 16, 0, 1'b0);
        run_instr(gen_op(K_R), K_R, 15, 0, 1'b0);
        run_instr(11'b11111000000, K_STUR, 0, 16, 1'b0);
        run_instr(11'b11111000000, K_STUR, 0, 15, 1'b0);
        run_instr(11'b11111000010, K_LDUR, 15, 15, 1'b0);
        stur_reset();
        run_instr(gen_op(K_R), K_R, 15, 0, 1'b0);
        for (int n = 0; n < 80; n++) begin
            kind = ($urandom_range(0, 19) == 0) ? K_ILL : int'($urandom_range(0, 5));
            fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
            run_instr(gen_op(kind), kind, fw, mw, 1'($urandom_range(0, 1)));
        end
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
